// File: rtl/gemm_insn_issue.sv
// Issue controller in front of the GEMM core: collects dependency tokens,
// streams one instruction over its full loop nest, lets the core pipeline
// drain and then returns completion tokens to the load/store modules.
module gemm_insn_issue #(
    parameter int INS_WIDTH    = 128,
    parameter int UPC_WIDTH    = 13,
    parameter int ITER_WIDTH   = 14,
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [INS_WIDTH-1:0] insn_in,
    input  logic                 insn_valid,
    output logic                 insn_ready,
    output logic [INS_WIDTH-1:0] insn_out,
    input  logic                 l2g_dep_valid,
    output logic                 l2g_dep_ready,
    input  logic                 s2g_dep_valid,
    output logic                 s2g_dep_ready,
    output logic                 g2l_dep_valid,
    input  logic                 g2l_dep_ready,
    output logic                 g2s_dep_valid,
    input  logic                 g2s_dep_ready,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] retired_cnt
);

    localparam int DW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES);
    localparam logic [ITER_WIDTH-1:0] ONE = 1;
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

    typedef enum logic [2:0] {S_IDLE, S_POP, S_EXEC, S_DRAIN, S_PUSH} state_t;

    state_t                 state, state_next;
    logic [INS_WIDTH-1:0]   insn_reg;
    logic                   got_prev, got_next, sent_prev, sent_next;
    logic [ITER_WIDTH-1:0]  uop_idx, in_cnt, out_cnt;
    logic [DW-1:0]          drain_cnt;
    logic [CNT_WIDTH-1:0]   retired_q;

    logic [2:0]             opcode;
    logic                   pop_prev, pop_next, push_prev, push_next;
    logic [UPC_WIDTH-1:0]   uop_bgn;
    logic [ITER_WIDTH-1:0]  uop_bgn_ext, uop_end, iter_out, iter_in;

    assign opcode      = insn_reg[2:0];
    assign pop_prev    = insn_reg[3];
    assign pop_next    = insn_reg[4];
    assign push_prev   = insn_reg[5];
    assign push_next   = insn_reg[6];
    assign uop_bgn     = insn_reg[20:8];
    assign uop_end     = insn_reg[34:21];
    assign iter_out    = insn_reg[48:35];
    assign iter_in     = insn_reg[62:49];
    assign uop_bgn_ext = {{(ITER_WIDTH-UPC_WIDTH){1'b0}}, uop_bgn};

    logic runnable;
    assign runnable = (opcode == 3'b010) && (iter_out != '0) && (iter_in != '0)
                      && (uop_end > uop_bgn_ext);

    // Handshake-facing outputs are forced low while reset is asserted
    assign insn_ready    = !rst && (state == S_IDLE);
    assign busy          = !rst && (state != S_IDLE);
    assign insn_out      = (!rst && state == S_EXEC) ? insn_reg : '0;
    assign l2g_dep_ready = !rst && (state == S_POP) && pop_prev && !got_prev;
    assign s2g_dep_ready = !rst && (state == S_POP) && pop_next && !got_next;
    assign g2l_dep_valid = !rst && (state == S_PUSH) && push_prev && !sent_prev;
    assign g2s_dep_valid = !rst && (state == S_PUSH) && push_next && !sent_next;
    assign retired_cnt   = rst ? '0 : retired_q;

    logic prev_take, next_take, prev_give, next_give;
    assign prev_take = l2g_dep_valid && l2g_dep_ready;
    assign next_take = s2g_dep_valid && s2g_dep_ready;
    assign prev_give = g2l_dep_valid && g2l_dep_ready;
    assign next_give = g2s_dep_valid && g2s_dep_ready;

    logic pop_done, push_done, uop_last, in_last, out_last, exec_last, drain_last;
    assign pop_done   = (!pop_prev || got_prev || prev_take) && (!pop_next || got_next || next_take);
    assign push_done  = (!push_prev || sent_prev || prev_give) && (!push_next || sent_next || next_give);
    assign uop_last   = (uop_idx == uop_end - ONE);
    assign in_last    = (in_cnt == iter_in - ONE);
    assign out_last   = (out_cnt == iter_out - ONE);
    assign exec_last  = uop_last && in_last && out_last;
    assign drain_last = (drain_cnt == DRAIN_LAST);

    // Next-state selection for the issue sequence
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (insn_valid) state_next = S_POP;
            S_POP:   if (pop_done) state_next = runnable ? S_EXEC : S_PUSH;
            S_EXEC:  if (exec_last) state_next = S_DRAIN;
            S_DRAIN: if (drain_last) state_next = S_PUSH;
            S_PUSH:  if (push_done) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // State register, token bookkeeping and the three nested loop counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            insn_reg  <= '0;
            got_prev  <= 1'b0;
            got_next  <= 1'b0;
            sent_prev <= 1'b0;
            sent_next <= 1'b0;
            uop_idx   <= '0;
            in_cnt    <= '0;
            out_cnt   <= '0;
            drain_cnt <= '0;
            retired_q <= '0;
        end else begin
            state <= state_next;
            case (state)
                S_IDLE: begin
                    if (insn_valid) begin
                        insn_reg  <= insn_in;
                        got_prev  <= 1'b0;
                        got_next  <= 1'b0;
                        sent_prev <= 1'b0;
                        sent_next <= 1'b0;
                    end
                end
                S_POP: begin
                    if (prev_take) got_prev <= 1'b1;
                    if (next_take) got_next <= 1'b1;
                    uop_idx   <= uop_bgn_ext;
                    in_cnt    <= '0;
                    out_cnt   <= '0;
                    drain_cnt <= '0;
                end
                S_EXEC: begin
                    if (uop_last) begin
                        uop_idx <= uop_bgn_ext;
                        if (in_last) begin
                            in_cnt  <= '0;
                            out_cnt <= out_cnt + ONE;
                        end else begin
                            in_cnt <= in_cnt + ONE;
                        end
                    end else begin
                        uop_idx <= uop_idx + ONE;
                    end
                end
                S_DRAIN: drain_cnt <= drain_cnt + 1'b1;
                S_PUSH: begin
                    if (prev_give) sent_prev <= 1'b1;
                    if (next_give) sent_next <= 1'b1;
                    if (push_done) retired_q <= retired_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gemm_insn_issue.sv
// Randomized bench for gemm_insn_issue: every cycle is checked against a
// timeline computed from the instruction fields and the chosen token timing.
module tb_gemm_insn_issue;

    localparam int INS_WIDTH = 128;
    localparam int CNT_WIDTH = 32;
    localparam int DRAIN     = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [INS_WIDTH-1:0] insn_in;
    logic                 insn_valid;
    logic                 insn_ready;
    logic [INS_WIDTH-1:0] insn_out;
    logic                 l2g_dep_valid, l2g_dep_ready;
    logic                 s2g_dep_valid, s2g_dep_ready;
    logic                 g2l_dep_valid, g2l_dep_ready;
    logic                 g2s_dep_valid, g2s_dep_ready;
    logic                 busy;
    logic [CNT_WIDTH-1:0] retired_cnt;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    logic [CNT_WIDTH-1:0] exp_retired = '0;

    gemm_insn_issue #(.DRAIN_CYCLES(DRAIN)) dut (
        .clk(clk), .rst(rst),
        .insn_in(insn_in), .insn_valid(insn_valid), .insn_ready(insn_ready),
        .insn_out(insn_out),
        .l2g_dep_valid(l2g_dep_valid), .l2g_dep_ready(l2g_dep_ready),
        .s2g_dep_valid(s2g_dep_valid), .s2g_dep_ready(s2g_dep_ready),
        .g2l_dep_valid(g2l_dep_valid), .g2l_dep_ready(g2l_dep_ready),
        .g2s_dep_valid(g2s_dep_valid), .g2s_dep_ready(g2s_dep_ready),
        .busy(busy), .retired_cnt(retired_cnt)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [127:0] make_insn(input logic [2:0] op, input logic pp, input logic pn,
                                               input logic qp, input logic qn, input logic [12:0] bgn,
                                               input logic [13:0] en, input logic [13:0] io,
                                               input logic [13:0] ii);
        logic [127:0] w;
        w = {$urandom, $urandom, $urandom, $urandom};
        w[2:0]   = op;
        w[3]     = pp;
        w[4]     = pn;
        w[5]     = qp;
        w[6]     = qn;
        w[20:8]  = bgn;
        w[34:21] = en;
        w[48:35] = io;
        w[62:49] = ii;
        return w;
    endfunction

    // One instruction from idle gap to retirement (or abort by reset).
    // pre_*: token valid rises at accept-1+pre; rp/rn: push ready delay in PUSH.
    task automatic applyStimulus(input logic [127:0] insn, input int pre_prev, input int pre_next,
                                 input int rp, input int rn, input int abort_at);
        logic [2:0] op;
        logic pp, pn, qp, qn, run, aborted;
        int bgn, en, io, ii, n, vp, vn, hp, hn, pend, e, s, q, gap;
        logic [127:0] exp_out;
        logic [5:0] exp_flags;
        op  = insn[2:0];
        pp  = insn[3];
        pn  = insn[4];
        qp  = insn[5];
        qn  = insn[6];
        bgn = int'(insn[20:8]);
        en  = int'(insn[34:21]);
        io  = int'(insn[48:35]);
        ii  = int'(insn[62:49]);
        run = (op == 3'd2) && io != 0 && ii != 0 && en > bgn;
        n   = run ? io * ii * (en - bgn) : 0;
        vp  = pre_prev - 1;
        vn  = pre_next - 1;
        hp  = (vp > 1) ? vp : 1;
        hn  = (vn > 1) ? vn : 1;
        pend = 1;
        if (pp && hp > pend) pend = hp;
        if (pn && hn > pend) pend = hn;
        e = pend + 1;
        s = run ? e + n + DRAIN : pend + 1;
        q = s;
        if (qp && s + rp > q) q = s + rp;
        if (qn && s + rn > q) q = s + rn;
        gap = 1 + ($urandom % 2);
        for (int j = -gap; j <= q; j++) begin
            @(negedge clk);
            cyc++;
            aborted       = (abort_at >= 0) && run && (j == e + abort_at);
            rst           = aborted;
            insn_valid    = (j == 0);
            insn_in       = (j == 0) ? insn : {$urandom, $urandom, $urandom, $urandom};
            l2g_dep_valid = pp ? (j >= vp && j <= hp) : 1'($urandom % 2);
            s2g_dep_valid = pn ? (j >= vn && j <= hn) : 1'($urandom % 2);
            g2l_dep_ready = qp ? (j >= s + rp) : 1'($urandom % 2);
            g2s_dep_ready = qn ? (j >= s + rn) : 1'($urandom % 2);
            #1;
            if (aborted) begin
                checkOutput("rst_insn_out", insn_out, '0);
                checkOutput("rst_flags", {122'd0, insn_ready, busy, l2g_dep_ready, s2g_dep_ready,
                                          g2l_dep_valid, g2s_dep_valid}, '0);
                exp_retired = '0;
                break;
            end
            exp_out   = (run && j >= e && j < e + n) ? insn : '0;
            exp_flags = {j <= 0, j > 0,
                         pp && j >= 1 && j <= hp,
                         pn && j >= 1 && j <= hn,
                         qp && j >= s && j <= s + rp,
                         qn && j >= s && j <= s + rn};
            checkOutput("insn_out", insn_out, exp_out);
            checkOutput("flags", {122'd0, insn_ready, busy, l2g_dep_ready, s2g_dep_ready,
                                  g2l_dep_valid, g2s_dep_valid}, {122'd0, exp_flags});
            checkOutput("retired_cnt", {96'd0, retired_cnt}, {96'd0, exp_retired});
            if (j == q) exp_retired++;
        end
    endtask

    initial begin
        rst = 1'b1;
        insn_in = '0;
        insn_valid = 1'b0;
        l2g_dep_valid = 1'b0;
        s2g_dep_valid = 1'b0;
        g2l_dep_ready = 1'b0;
        g2s_dep_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset_insn_out", insn_out, '0);
        checkOutput("reset_flags", {122'd0, insn_ready, busy, l2g_dep_ready, s2g_dep_ready,
                                    g2l_dep_valid, g2s_dep_valid}, '0);
        checkOutput("reset_retired", {96'd0, retired_cnt}, '0);

        // Full loop nest of 24 cycles, no dependencies
        applyStimulus(make_insn(3'd2, 0, 0, 0, 0, 13'd0, 14'd4, 14'd2, 14'd3), 0, 0, 0, 0, -1);
        // Minimum latency, N = 1
        applyStimulus(make_insn(3'd2, 0, 0, 0, 0, 13'd5, 14'd6, 14'd1, 14'd1), 0, 0, 0, 0, -1);
        // Both pops, tokens arriving at +5 and +9
        applyStimulus(make_insn(3'd2, 1, 1, 0, 0, 13'd1, 14'd3, 14'd1, 14'd2), 6, 10, 0, 0, -1);
        // Both pushes, store side stalls for 6 cycles
        applyStimulus(make_insn(3'd2, 0, 0, 1, 1, 13'd0, 14'd2, 14'd1, 14'd1), 0, 0, 0, 6, -1);
        // Zero inner iterations still pushes its token
        applyStimulus(make_insn(3'd2, 0, 0, 0, 1, 13'd0, 14'd4, 14'd2, 14'd0), 0, 0, 0, 2, -1);
        // ALU opcode consumes its token without executing
        applyStimulus(make_insn(3'd4, 1, 0, 0, 0, 13'd0, 14'd4, 14'd2, 14'd3), 3, 0, 0, 0, -1);
        // Reset mid-EXEC aborts, then a full instruction runs
        applyStimulus(make_insn(3'd2, 0, 0, 1, 1, 13'd0, 14'd4, 14'd2, 14'd3), 0, 0, 0, 0, 10);
        applyStimulus(make_insn(3'd2, 0, 0, 1, 1, 13'd0, 14'd4, 14'd2, 14'd3), 0, 0, 1, 0, -1);

        // Randomized instructions with random token timing
        for (int t = 0; t < 40; t++) begin
            logic [2:0] op;
            op = (($urandom % 4) == 0) ? 3'($urandom % 8) : 3'd2;
            applyStimulus(make_insn(op, 1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 2),
                                    1'($urandom % 2), 13'($urandom % 4), 14'($urandom % 7),
                                    14'($urandom % 4), 14'($urandom % 4)),
                          int'($urandom % 8), int'($urandom % 8),
                          int'($urandom % 5), int'($urandom % 5), -1);
        end

        // Trailing idle check after the last retirement
        @(negedge clk);
        rst = 1'b0;
        insn_valid = 1'b0;
        #1;
        checkOutput("final_retired", {96'd0, retired_cnt}, {96'd0, exp_retired});
        checkOutput("final_ready", {127'd0, insn_ready}, 128'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
